// File: rtl/cxs_rxflit_ctrl.sv
// CXS RX flit RAM sequencer: credit grant, flit write into a circular slot queue,
// word reads of the head flit for the host. Optional counters: CXS_RXFLIT_CTRL_STATS_EN.
module cxs_rxflit_ctrl #(
  parameter int AWIDTH  = 4,
  parameter int WWIDTH  = 128,
  parameter int MAX_CRD = 15,
  parameter     OREG_B  = "TRUE",
  localparam int NW     = WWIDTH / 32,
  localparam int WSELW  = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cxs_rx_valid,
  input  logic [WWIDTH-1:0] cxs_rx_data,
  output logic              cxs_rx_crdgnt,
  input  logic              rd_req,
  input  logic [WSELW-1:0]  rd_word,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  input  logic              pop,
  output logic [AWIDTH:0]   occupancy,
  output logic              proto_err,
`ifdef CXS_RXFLIT_CTRL_STATS_EN
  output logic [31:0]       flit_cnt,
  output logic [15:0]       drop_cnt,
`endif
  output logic              ram_en_a,
  output logic              ram_we_a,
  output logic [AWIDTH-1:0] ram_addr_a,
  output logic [WWIDTH-1:0] ram_wr_data_a,
  output logic              ram_en_b,
  output logic              ram_we_b,
  output logic [AWIDTH-1:0] ram_addr_b,
  output logic [NW-1:0]     ram_word_en_b,
  output logic              ram_oreg_ce_b,
  input  logic [31:0]       ram_rd_data_b
);
  localparam int RL = (OREG_B == "TRUE") ? 2 : 1;
  localparam logic [AWIDTH+1:0] DEPTH_W = (AWIDTH+2)'(1 << AWIDTH);
  localparam logic [AWIDTH:0]   MAX_W   = (AWIDTH+1)'(MAX_CRD);
  localparam logic [AWIDTH:0]   ONE     = (AWIDTH+1)'(1);

  typedef enum logic {IDLE, WAIT} rd_state_t;

  rd_state_t         state, state_nxt;
  logic [1:0]        cnt;
  logic [AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [AWIDTH:0]   crd_out;
  logic              wr_fire, drop, rd_acc, pop_ok, rd_done, not_empty;

  assign not_empty     = (occupancy != '0);
  assign wr_fire       = !rst && cxs_rx_valid && (crd_out != '0);
  assign drop          = !rst && cxs_rx_valid && (crd_out == '0);
  // Outstanding credits plus filled slots never exceed the slot count.
  assign cxs_rx_crdgnt = !rst && (({1'b0, occupancy} + {1'b0, crd_out}) < DEPTH_W)
                         && (crd_out < MAX_W);
  assign rd_ready      = !rst && (state == IDLE);
  assign rd_acc        = rd_ready && rd_req && not_empty;
  assign pop_ok        = rd_ready && pop && not_empty;
  assign rd_done       = (state == WAIT) && (cnt == 2'd1);

  assign ram_en_a      = wr_fire;
  assign ram_we_a      = wr_fire;
  assign ram_addr_a    = wr_fire ? wr_ptr : '0;
  assign ram_wr_data_a = wr_fire ? cxs_rx_data : '0;
  assign ram_we_b      = 1'b0;

  always_comb begin
    state_nxt     = state;
    ram_en_b      = 1'b0;
    ram_addr_b    = '0;
    ram_word_en_b = '0;
    ram_oreg_ce_b = 1'b0;
    case (state)
      IDLE: if (rd_acc) begin
        ram_en_b      = 1'b1;
        ram_addr_b    = rd_ptr;
        ram_word_en_b = NW'(1) << rd_word;
        state_nxt     = WAIT;
      end
      WAIT: begin
        ram_oreg_ce_b = 1'b1;
        if (rd_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      crd_out   <= '0;
      proto_err <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      state    <= state_nxt;
      // cnt holds the cycles left until the port-B data is stable.
      if (rd_acc)              cnt <= 2'(RL);
      else if (state == WAIT)  cnt <= cnt - 2'd1;
      rd_valid <= rd_done;
      if (rd_done) rd_data <= ram_rd_data_b;
      if (wr_fire) wr_ptr <= wr_ptr + AWIDTH'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AWIDTH'(1);
      case ({wr_fire, pop_ok})
        2'b10:   occupancy <= occupancy + ONE;
        2'b01:   occupancy <= occupancy - ONE;
        default: occupancy <= occupancy;
      endcase
      case ({cxs_rx_crdgnt, wr_fire})
        2'b10:   crd_out <= crd_out + ONE;
        2'b01:   crd_out <= crd_out - ONE;
        default: crd_out <= crd_out;
      endcase
      if (drop) proto_err <= 1'b1;
    end
  end

`ifdef CXS_RXFLIT_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr_fire) flit_cnt <= flit_cnt + 32'd1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cxs_rxflit_ctrl.sv
// Bench for cxs_rxflit_ctrl: directed stimulus, queue-based reference model
// compared every cycle, plus literal expectations at key points.
module tb_cxs_rxflit_ctrl;
  localparam int AW = 4, WW = 128, NW = 4, RL = 2, DEPTH = 16, MAXC = 15;

  logic          clk, rst;
  logic          cxs_rx_valid, cxs_rx_crdgnt;
  logic [WW-1:0] cxs_rx_data;
  logic          rd_req, rd_ready, rd_valid, pop, proto_err;
  logic [1:0]    rd_word;
  logic [31:0]   rd_data;
  logic [AW:0]   occupancy;
  logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b, ram_oreg_ce_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [WW-1:0] ram_wr_data_a;
  logic [NW-1:0] ram_word_en_b;
  logic [31:0]   ram_rd_data_b;
`ifdef CXS_RXFLIT_CTRL_STATS_EN
  logic [31:0]   flit_cnt;
  logic [15:0]   drop_cnt;
`endif

  cxs_rxflit_ctrl #(.AWIDTH(AW), .WWIDTH(WW), .MAX_CRD(MAXC), .OREG_B("TRUE")) dut (
    .clk(clk), .rst(rst), .cxs_rx_valid(cxs_rx_valid), .cxs_rx_data(cxs_rx_data),
    .cxs_rx_crdgnt(cxs_rx_crdgnt), .rd_req(rd_req), .rd_word(rd_word),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .pop(pop),
    .occupancy(occupancy), .proto_err(proto_err),
`ifdef CXS_RXFLIT_CTRL_STATS_EN
    .flit_cnt(flit_cnt), .drop_cnt(drop_cnt),
`endif
    .ram_en_a(ram_en_a), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a),
    .ram_wr_data_a(ram_wr_data_a), .ram_en_b(ram_en_b), .ram_we_b(ram_we_b),
    .ram_addr_b(ram_addr_b), .ram_word_en_b(ram_word_en_b),
    .ram_oreg_ce_b(ram_oreg_ce_b), .ram_rd_data_b(ram_rd_data_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flit RAM: wide port A, 32-bit port B with an output register.
  logic [WW-1:0] mem [DEPTH];
  logic [31:0]   s1, s2;
  always @(posedge clk) begin
    if (ram_en_a && ram_we_a) mem[ram_addr_a] <= ram_wr_data_a;
    if (ram_en_b)
      for (int w = 0; w < NW; w++)
        if (ram_word_en_b[w]) s1 <= mem[ram_addr_b][w*32 +: 32];
    if (ram_oreg_ce_b) s2 <= s1;
  end
  assign ram_rd_data_b = s2;

  int checks = 0, failures = 0;
  task automatic cmp(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  // Reference model: queue of stored flits, credit count, pending read timed in cycles.
  logic [WW-1:0] q[$];
  int   crd, wp, rp, cyc, acc_cyc;
  bit   pend, perr, mvalid;
  logic [31:0] pdata, mrdata;

  always @(negedge clk) begin
    if (rst) begin
      q.delete(); crd = 0; wp = 0; rp = 0; cyc = 0; acc_cyc = 0;
      pend = 0; perr = 0; mvalid = 0; mrdata = '0; pdata = '0;
    end else begin
      automatic bit busy = pend && (cyc > acc_cyc) && (cyc <= acc_cyc + RL);
      automatic bit nz   = q.size() > 0;
      automatic bit gnt  = (q.size() + crd < DEPTH) && (crd < MAXC);
      automatic bit wr   = cxs_rx_valid && (crd > 0);
      automatic bit acc  = rd_req && !busy && nz;
      automatic bit pp   = pop && !busy && nz;
      automatic logic [WW-1:0] head = nz ? q[0] : '0;
      automatic logic [NW-1:0] wsel = NW'(1) << rd_word;
      cmp("model.crdgnt", cxs_rx_crdgnt, gnt);
      cmp("model.occupancy", occupancy, q.size());
      cmp("model.proto_err", proto_err, perr);
      cmp("model.rd_ready", rd_ready, !busy);
      cmp("model.rd_valid", rd_valid, mvalid);
      cmp("model.rd_data", rd_data, mrdata);
      cmp("model.ram_en_a", ram_en_a, wr);
      cmp("model.ram_we_a", ram_we_a, wr);
      cmp("model.ram_addr_a", ram_addr_a, wr ? wp : 0);
      cmp("model.ram_wr_data_a", ram_wr_data_a, wr ? cxs_rx_data : '0);
      cmp("model.ram_en_b", ram_en_b, acc);
      cmp("model.ram_we_b", ram_we_b, 0);
      cmp("model.ram_addr_b", ram_addr_b, acc ? rp : 0);
      cmp("model.ram_word_en_b", ram_word_en_b, acc ? wsel : '0);
      cmp("model.ram_oreg_ce_b", ram_oreg_ce_b, busy);
      if (pend && cyc == acc_cyc + RL) begin mvalid = 1; mrdata = pdata; pend = 0; end
      else mvalid = 0;
      if (acc) begin pend = 1; acc_cyc = cyc; pdata = head[rd_word*32 +: 32]; end
      if (pp) begin void'(q.pop_front()); rp = (rp + 1) % DEPTH; end
      if (wr) begin q.push_back(cxs_rx_data); wp = (wp + 1) % DEPTH; end
      if (cxs_rx_valid && crd == 0) perr = 1;
      crd = crd + int'(gnt) - int'(wr);
      cyc++;
    end
  end

  function automatic logic [WW-1:0] mk(input int i);
    return {32'(i*16+3), 32'(i*16+2), 32'(i*16+1), 32'(i*16)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int g;

  initial begin
    rst = 1; cxs_rx_valid = 0; cxs_rx_data = '0; rd_req = 0; rd_word = '0; pop = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("rst.crdgnt", cxs_rx_crdgnt, 0);
    cmp("rst.occupancy", occupancy, 0);
    cmp("rst.proto_err", proto_err, 0);
    cmp("rst.rd_valid", rd_valid, 0);
    tick(); rst = 0;

    // Boot: 15 grants in the first 15 cycles, then silence.
    g = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); if (k == 0) cmp("boot.rd_ready", rd_ready, 1);
      g += int'(cxs_rx_crdgnt); tick();
    end
    cmp("boot.grants15", g, 15);
    g = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); g += int'(cxs_rx_crdgnt); tick(); end
    cmp("boot.grants_after", g, 0);

    // Fill all 16 slots.
    for (int i = 0; i < 16; i++) begin cxs_rx_valid = 1; cxs_rx_data = mk(i); tick(); end
    cxs_rx_valid = 0;
    @(negedge clk); cmp("fill.occupancy", occupancy, 16);
    g = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); g += int'(cxs_rx_crdgnt); tick(); end
    cmp("full.grants", g, 0);

    // Read word 2 of flit 0; pop during WAIT must be ignored.
    rd_req = 1; rd_word = 2'd2; tick();
    rd_req = 0; pop = 1;
    @(negedge clk); cmp("rd.ready_c1", rd_ready, 0); cmp("rd.valid_c1", rd_valid, 0);
    tick(); pop = 0;
    @(negedge clk); cmp("rd.ready_c2", rd_ready, 0); cmp("rd.valid_c2", rd_valid, 0);
    tick();
    @(negedge clk);
    cmp("rd.valid_c3", rd_valid, 1);
    cmp("rd.data_c3", rd_data, 32'h2);
    cmp("rd.pop_in_wait", occupancy, 16);
    tick();
    @(negedge clk); cmp("rd.valid_pulse", rd_valid, 0); cmp("rd.data_hold", rd_data, 32'h2);

    // One pop frees one credit.
    pop = 1; tick(); pop = 0;
    g = 0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); g += int'(cxs_rx_crdgnt); tick(); end
    cmp("pop.one_grant", g, 1);

    // Consume it, then a flit with no credit is dropped.
    cxs_rx_valid = 1; cxs_rx_data = mk(16); tick();
    cxs_rx_data = mk(99);
    @(negedge clk); cmp("drop.no_ram_write", ram_en_a, 0);
    tick(); cxs_rx_valid = 0;
    @(negedge clk);
    cmp("drop.proto_err", proto_err, 1);
    cmp("drop.occupancy", occupancy, 16);
`ifdef CXS_RXFLIT_CTRL_STATS_EN
    cmp("stats.drop_cnt", drop_cnt, 1);
    cmp("stats.flit_cnt", flit_cnt, 17);
`endif

    // Drain to 5, then write+pop together across the rd_ptr wrap (12 -> 2).
    pop = 1; repeat (11) tick(); pop = 0;
    @(negedge clk); cmp("drain.occupancy5", occupancy, 5);
    for (int i = 0; i < 6; i++) begin
      cxs_rx_valid = 1; cxs_rx_data = mk(20 + i); pop = 1; tick();
      if (i == 0) begin @(negedge clk); cmp("wp.occupancy_first", occupancy, 5); end
    end
    cxs_rx_valid = 0; pop = 0;
    @(negedge clk); cmp("wp.occupancy", occupancy, 5);
    rd_req = 1; rd_word = 2'd1; tick(); rd_req = 0; tick(); tick();
    @(negedge clk); cmp("wrap.rd_valid", rd_valid, 1); cmp("wrap.rd_data", rd_data, 32'h151);
    tick();

    // Empty: pop and rd_req ignored.
    pop = 1; repeat (5) tick(); pop = 0;
    @(negedge clk); cmp("empty.occupancy", occupancy, 0);
    pop = 1; rd_req = 1; tick(); pop = 0; rd_req = 0;
    g = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); g += int'(rd_valid); tick(); end
    cmp("empty.no_rd_valid", g, 0);

    // Reset during a read aborts it.
    cxs_rx_valid = 1; cxs_rx_data = mk(40); tick(); cxs_rx_valid = 0;
    rd_req = 1; tick(); rd_req = 0; rst = 1; tick(); rst = 0;
    g = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); g += int'(rd_valid); tick(); end
    cmp("rstmid.no_rd_valid", g, 0);
    @(negedge clk);
    cmp("rstmid.occupancy", occupancy, 0);
    cmp("rstmid.proto_err", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cxs_rxflit_ctrl.md
Name: cxs_rxflit_ctrl

Overview:
Controller that sequences the CXS RX flit RAM. It grants CXS receive credits, writes each arriving flit into the next free RAM slot through port A, and maintains a circular slot queue. The host register block reads the head flit 32 bits at a time through port B, then pops it. Popping frees the slot and allows a new credit to be granted.

Parameters:
AWIDTH, 4, RAM address width; DEPTH = 2^AWIDTH flit slots
WWIDTH, 128, flit width in bits; multiple of 32, NW = WWIDTH/32 words per flit
MAX_CRD, 15, maximum outstanding credits; legal range 1..DEPTH
OREG_B, "TRUE", must match the RAM port-B output register setting; read latency RL = 2 if "TRUE", else 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cxs_rx_valid  in  1  flit valid, one flit per cycle
cxs_rx_data  in  WWIDTH  flit payload
cxs_rx_crdgnt  out  1  credit grant pulse, one credit per cycle
rd_req  in  1  host word-read request
rd_word  in  clog2(NW)  word index within the head flit
rd_ready  out  1  high when no read is in flight
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_data  out  32  selected word
pop  in  1  release the head slot
occupancy  out  AWIDTH+1  number of filled slots
proto_err  out  1  sticky: flit arrived with no outstanding credit
ram_en_a, ram_we_a  out  1  port A enable and write enable
ram_addr_a  out  AWIDTH  port A address
ram_wr_data_a  out  WWIDTH  port A write data
ram_en_b  out  1  port B enable
ram_we_b  out  1  tied 0
ram_addr_b  out  AWIDTH  port B address
ram_word_en_b  out  NW  one-hot word select
ram_oreg_ce_b  out  1  port B output register enable
ram_rd_data_b  in  32  port B read data

Behaviour:
- Reset values: all outputs 0. Internal state also clears: wr_ptr, rd_ptr, occupancy, crd_out (outstanding credits), proto_err, and the read FSM returns to IDLE. rd_ready is 1 after reset.
- Credit grant: cxs_rx_crdgnt is asserted in a cycle when (occupancy + crd_out) < DEPTH and crd_out < MAX_CRD. The first grant appears in the first cycle after rst deasserts.
- Flit write: when cxs_rx_valid=1 and crd_out>0:
  - drive ram_en_a=ram_we_a=1, ram_addr_a=wr_ptr, ram_wr_data_a=cxs_rx_data in the same cycle (combinational);
  - wr_ptr increments mod DEPTH; occupancy increments; crd_out decrements.
- Grant and flit in the same cycle: crd_out is unchanged.
- Protocol error: if cxs_rx_valid=1 while crd_out=0, the flit is dropped, no RAM write occurs, and proto_err is set. Only rst clears proto_err.
- Read FSM, states IDLE -> WAIT -> IDLE:
  - IDLE: rd_ready=1. rd_req with occupancy>0 drives ram_en_b=1, ram_addr_b=rd_ptr, ram_word_en_b=1<<rd_word, then moves to WAIT with count=RL.
  - rd_req with occupancy=0 is ignored; no rd_valid is produced.
  - WAIT: rd_ready=0. ram_oreg_ce_b=1 throughout WAIT. The count decrements each cycle. When the count reaches 0, rd_valid=1, rd_data=ram_rd_data_b, and the FSM returns to IDLE.
  - rd_valid therefore rises RL+1 cycles after the accepted rd_req edge (3 cycles for OREG_B "TRUE").
  - rd_data holds its value until the next rd_valid.
- Pop:
  - accepted only when rd_ready=1 and occupancy>0; rd_ptr then increments mod DEPTH and occupancy decrements;
  - pop while empty or while a read is in flight is ignored;
  - flit write and pop in the same cycle leave occupancy unchanged.
- Pointer wrap: pointers wrap from DEPTH-1 to 0. Full condition is occupancy=DEPTH; the credit rule guarantees no flit arrives while full.
- rst mid-read: the FSM aborts, no rd_valid is issued, and all credits are forgotten. The link must be retrained by the partner.

Optional Feature:
- Macro CXS_RXFLIT_CTRL_STATS_EN.
- Defined: adds output flit_cnt (32 bits) and output drop_cnt (16 bits).
  - flit_cnt increments on every written flit and wraps.
  - drop_cnt increments on every dropped flit and saturates at 0xFFFF.
  - Both clear on rst.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset release, host idle, DEPTH=16, MAX_CRD=15 -> exactly 15 crdgnt pulses in the first 15 cycles, then crdgnt stays 0.
- Send 16 flits while credits are returned by the grant rule -> occupancy=16; grants stop until a pop, then exactly one grant follows each pop.
- Write flit 0x000000030000000200000001_00000000, then rd_req with rd_word=2 -> rd_valid 3 cycles later with rd_data=0x00000002; rd_ready low for those cycles.
- cxs_rx_valid pulsed with crd_out=0 -> proto_err=1, occupancy unchanged, no RAM write (and drop_cnt=1 with STATS_EN).
- Simultaneous flit write and pop with occupancy=5 -> occupancy stays 5; wr_ptr and rd_ptr both advance; pointer wrap from 15 to 0 is checked.
- pop and rd_req while empty, plus pop during WAIT -> all ignored, no rd_valid, occupancy unchanged.
